mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 19 +
 rtl/mem_resp_if.sv | 23 ++
 rtl/mem_resp_ram.sv | 25 ++
 rtl/mem_responder.sv | 94 +++++++++
 tb/tb_mem_responder.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_resp_pkg.sv
// Shared constants, FSM encoding and request bundle for the memory responder.
package mem_resp_pkg;
  localparam int unsigned DEPTH    = 256;
  localparam int unsigned RD_LAT   = 2;
  localparam int unsigned ADDR_LSB = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;
endpackage

// File: rtl/mem_resp_if.sv
// Request/response bus between the EX/MEM stage (master) and the responder (slave).
interface mem_resp_if;
  logic        EN;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        W_in;
  logic        R_in;
  logic        Ack;
  logic        Busy;
  logic [31:0] RData;
  logic        RValid;
  logic        Err;

  modport master (
    output EN, Addr, WData, W_in, R_in,
    input  Ack, Busy, RData, RValid, Err
  );

  modport slave (
    input  EN, Addr, WData, W_in, R_in,
    output Ack, Busy, RData, RValid, Err
  );
endinterface

// File: rtl/mem_resp_ram.sv
// DEPTH x 32 storage: one synchronous write port, one registered read port.
// Contents are never reset.
module mem_resp_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // write and registered read share the clock; caller never overlaps them
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder: writes complete at acceptance, reads return
// two edges after acceptance; malformed requests are flagged with Err.
module mem_responder #(
  parameter int unsigned DEPTH  = mem_resp_pkg::DEPTH,
  parameter int unsigned RD_LAT = mem_resp_pkg::RD_LAT
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_resp_if.slave  bus
);
  import mem_resp_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  // the FSM below hard-codes two read states
  if (RD_LAT != 2) begin : g_rd_lat_chk
    $error("mem_responder: only RD_LAT == 2 is implemented");
  end

  state_t        r_state, w_next;
  req_t          w_req;
  logic          w_acc, w_misal, w_oob, w_reject, w_rd_go, w_wr_go, w_ram_re;
  logic [31:0]   w_word;
  logic [AW-1:0] w_idx, r_ridx;
  logic [31:0]   w_ram_q, r_rdata;
  logic          r_rvalid, r_err;

  assign w_req    = '{we: bus.W_in, re: bus.R_in, addr: bus.Addr, wdata: bus.WData};
  assign w_word   = 32'(w_req.addr >> ADDR_LSB);
  assign w_idx    = w_req.addr[ADDR_LSB +: AW];
  assign w_misal  = (w_req.addr[ADDR_LSB-1:0] != '0);
  assign w_oob    = (w_word >= 32'(DEPTH));
  // a no-op carries no address, so only real operations can be rejected
  assign w_reject = (w_req.we | w_req.re) & ((w_req.we & w_req.re) | w_misal | w_oob);
  assign w_rd_go  = w_acc & w_req.re & ~w_req.we & ~w_misal & ~w_oob;
  assign w_wr_go  = w_acc & w_req.we & ~w_req.re & ~w_misal & ~w_oob;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // next-state: a read walks RD1 -> RD2 -> IDLE unconditionally
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_rd_go) w_next = RD1;
      RD1:     w_next = RD2;
      RD2:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // outputs: accept only when idle and out of reset; RAM read fires in RD1
  always_comb begin
    w_acc    = bus.EN & rst_n & (r_state == IDLE);
    w_ram_re = (r_state == RD1);
    bus.Ack  = w_acc;
    bus.Busy = (r_state != IDLE);
  end

  // read word index captured at acceptance so later Addr changes are ignored
  always_ff @(posedge clk) begin
    if (w_rd_go) r_ridx <= w_idx;
  end

  // response registers: Err one cycle after a rejected accept, RValid after RD2
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err    <= w_acc & w_reject;
      r_rvalid <= (r_state == RD2);
      if (r_state == RD2) r_rdata <= w_ram_q;
    end
  end

  assign bus.RData  = r_rdata;
  assign bus.RValid = r_rvalid;
  assign bus.Err    = r_err;

  mem_resp_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .i_clk   (clk),
    .i_we    (w_wr_go),
    .i_waddr (w_idx),
    .i_wdata (w_req.wdata),
    .i_re    (w_ram_re),
    .i_raddr (r_ridx),
    .o_rdata (w_ram_q)
  );
endmodule

// File: tb/tb_mem_responder.sv
// Directed + randomized bench for mem_responder with a transaction-level model.
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst_n;
  mem_resp_if bus();

  mem_responder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model state: word contents, read in flight, expected registered outputs
  logic [31:0] mm [256];
  bit          mv [256];
  int          cyc = 0;
  bit          m_pend = 0;
  int          m_done = 0;
  logic [31:0] m_pdata = '0;
  bit          m_pknown = 0;
  logic [31:0] m_rdata = '0;
  bit          m_rd_known = 0;
  bit          m_rvalid = 0;
  bit          m_err = 0;
  bit          last_ack = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit is_bad(input bit w, input bit r, input logic [31:0] a);
    if (!w && !r) return 0;
    if (w && r) return 1;
    if (a % 4 != 0) return 1;
    if (a / 4 >= 256) return 1;
    return 0;
  endfunction

  // one clock: check Ack before the edge, advance the model, check outputs after
  task automatic step();
    bit acc, w, r;
    logic [31:0] a, d;
    #1;
    acc = bus.EN && rst_n && !m_pend;
    w = bus.W_in; r = bus.R_in; a = bus.Addr; d = bus.WData;
    chk("ack", {31'b0, bus.Ack}, {31'b0, acc});
    last_ack = acc;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_pend = 0; m_rdata = '0; m_rd_known = 1; m_rvalid = 0; m_err = 0;
    end else begin
      m_rvalid = 0; m_err = 0;
      if (m_pend && cyc == m_done) begin
        m_pend = 0; m_rvalid = 1; m_rdata = m_pdata; m_rd_known = m_pknown;
      end
      if (acc) begin
        if (is_bad(w, r, a)) m_err = 1;
        else if (w) begin mm[a/4] = d; mv[a/4] = 1; end
        else if (r) begin
          m_pend = 1; m_done = cyc + 2; m_pdata = mm[a/4]; m_pknown = mv[a/4];
        end
      end
    end
    @(negedge clk);
    chk("busy",   {31'b0, bus.Busy},   {31'b0, m_pend});
    chk("rvalid", {31'b0, bus.RValid}, {31'b0, m_rvalid});
    chk("err",    {31'b0, bus.Err},    {31'b0, m_err});
    if (m_rd_known) chk("rdata", bus.RData, m_rdata);
  endtask

  task automatic idle(input int n);
    bus.EN = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  // drive a request and hold it until accepted (bounded)
  task automatic issue(input bit w, input bit r, input logic [31:0] a,
                       input logic [31:0] d, input bit hold, output int acyc);
    bus.EN = 1; bus.W_in = w; bus.R_in = r; bus.Addr = a; bus.WData = d;
    for (int i = 0; i < 12; i++) begin
      step();
      if (last_ack) break;
    end
    chk("ack_timeout", {31'b0, last_ack}, 32'd1);
    acyc = cyc;
    if (!hold) bus.EN = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, k;
    bit act;
    bit w, r;
    logic [31:0] addr;
    int kind;
    for (int i = 0; i < 256; i++) begin mm[i] = '0; mv[i] = 0; end
    rst_n = 0;
    bus.EN = 1; bus.W_in = 1; bus.R_in = 0; bus.Addr = 32'h10; bus.WData = 32'h1234;
    @(negedge clk);
    // reset: Ack held low even with EN, outputs cleared
    for (int i = 0; i < 3; i++) step();
    chk("rst_rdata", bus.RData, 32'h0);
    rst_n = 1;
    idle(1);

    // write then read of the same word
    issue(1, 0, 32'h10, 32'hDEADBEEF, 0, a0);
    issue(0, 1, 32'h10, 32'h0, 0, a0);
    chk("r030_busy_rd1", {31'b0, bus.Busy}, 32'd1);
    idle(2);
    chk("r030_data", bus.RData, 32'hDEADBEEF);
    chk("r030_rvalid_lat", {31'b0, bus.RValid}, 32'd1);
    idle(1);

    // back-to-back reads with EN held
    issue(1, 0, 32'h0, 32'd1, 0, a0);
    issue(1, 0, 32'h4, 32'd2, 0, a0);
    issue(1, 0, 32'h8, 32'd3, 0, a0);
    issue(0, 1, 32'h0, 32'h0, 1, a0);
    issue(0, 1, 32'h4, 32'h0, 1, a1);
    chk("b2b_rdata1", bus.RData, 32'd1);
    issue(0, 1, 32'h8, 32'h0, 0, a2);
    chk("b2b_rdata2", bus.RData, 32'd2);
    chk("b2b_gap1", 32'(a1 - a0), 32'd3);
    chk("b2b_gap2", 32'(a2 - a1), 32'd3);
    idle(2);
    chk("b2b_rdata3", bus.RData, 32'd3);
    idle(1);

    // rejected requests leave RAM and FSM alone
    issue(1, 0, 32'h20, 32'hA5A5_0020, 0, a0);
    issue(1, 1, 32'h20, 32'hBAD0_0000, 0, a0);
    issue(0, 1, 32'h22, 32'h0, 0, a0);
    issue(0, 1, 32'h400, 32'h0, 0, a0);
    issue(1, 0, 32'h402, 32'hBAD1_0000, 0, a0);
    idle(3);
    issue(0, 1, 32'h20, 32'h0, 0, a0);
    idle(3);
    chk("rej_word20", bus.RData, 32'hA5A5_0020);

    // write while busy is deferred to edge k+3
    issue(0, 1, 32'h10, 32'h0, 0, a0);
    issue(1, 0, 32'h30, 32'h55, 0, a1);
    chk("busy_wr_gap", 32'(a1 - a0), 32'd3);
    issue(0, 1, 32'h30, 32'h0, 0, a0);
    idle(3);
    chk("busy_wr_data", bus.RData, 32'h55);

    // reset during RD2 aborts the read
    issue(1, 0, 32'h40, 32'hCAFE_F00D, 0, a0);
    issue(0, 1, 32'h40, 32'h0, 0, a0);
    idle(1);
    rst_n = 0;
    step();
    chk("rst_mid_rdata", bus.RData, 32'h0);
    chk("rst_mid_busy", {31'b0, bus.Busy}, 32'd0);
    rst_n = 1;
    idle(3);
    issue(0, 1, 32'h40, 32'h0, 0, a0);
    idle(3);
    chk("rst_mid_keep", bus.RData, 32'hCAFE_F00D);

    // no-op: acknowledged, nothing else
    issue(0, 0, 32'h10, 32'hFFFF_FFFF, 0, a0);
    chk("noop_err", {31'b0, bus.Err}, 32'd0);
    idle(1);
    issue(0, 1, 32'h10, 32'h0, 0, a0);
    idle(3);
    chk("noop_keep", bus.RData, 32'hDEADBEEF);

    // randomized traffic; occasionally an unaccepted request is swapped out
    act = 0;
    for (int i = 0; i < 600; i++) begin
      if (!act || $urandom_range(0, 19) == 0) begin
        kind = $urandom_range(0, 9);
        w = (kind >= 1 && kind <= 4) || kind == 9;
        r = (kind >= 5);
        addr = 32'($urandom_range(0, 255)) << 2;
        k = $urandom_range(0, 9);
        if (kind != 0 && k == 0) addr = addr | 32'($urandom_range(1, 3));
        else if (kind != 0 && k == 1) addr = (32'($urandom_range(256, 4000)) << 2);
        else if (kind != 0 && k == 2) addr = $urandom | 32'h8000_0000;
        bus.W_in = w; bus.R_in = r; bus.Addr = addr; bus.WData = $urandom;
        bus.EN = ($urandom_range(0, 3) != 0);
        act = bus.EN;
      end
      step();
      if (last_ack) begin
        act = 0;
        bus.Addr = $urandom;
        if ($urandom_range(0, 1) == 1) bus.EN = 0;
      end
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
